dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Clocked sequencer and arbiter in front of the byte-addressed data memory. The memory samples its strobes on edges, so this block turns single-cycle requests from two masters into clean setup/strobe/hold sequences on that memory. Master 0 is the core load/store path; master 1 is the debug/loader port. The block also checks alignment, sign-extends sub-word loads and flags timeouts.

Parameters:
WIDTH, 32, data/address width.
TIMEOUT, 4, max cycles with mem_rd high waiting for mem_rd_st before error.

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
p0_req  in  1  master 0 request; level, held until p0_ack.
p0_we  in  1  1=store, 0=load.
p0_addr  in  WIDTH  byte address.
p0_wdata  in  WIDTH  store data, right-justified.
p0_mode  in  2  0=word, 1=halfword, 2=byte, 3=illegal.
p0_sext  in  1  sign-extend sub-word load.
p0_ack  out  1  one-cycle completion pulse.
p0_rdata  out  WIDTH  load result, valid with p0_ack.
p0_err  out  1  error flag, valid with p0_ack.
p1_*  same nine signals for master 1.
mem_addr  out  WIDTH  memory address.
mem_wdata  out  WIDTH  store data to memory bus.
mem_wdata_oe  out  1  bus drive enable (top level tristates mem_wdata onto the inout data bus).
mem_rdata  in  WIDTH  memory bus read value.
mem_mode  out  2  data_mode to memory.
mem_wr  out  1  write strobe (memory acts on rising edge).
mem_rd  out  1  read strobe (memory drives bus while high).
mem_rd_st  in  1  memory read-status.
busy  out  1  FSM not IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, round-robin pointer favours p0.
- Reset mid-transaction aborts it: strobes drop immediately, no ack is issued, and the masters must re-request.
- FSM states: IDLE, SETUP, STROBE, HOLD, CAPTURE, DONE.
- IDLE arbitration: if exactly one req, grant it. If both, grant the port the pointer favours, then point the pointer at the other port. All request fields are latched on grant.
- Validation at grant:
  - mode=3 -> error.
  - word with addr[1:0]!=0 -> error.
  - halfword with addr[0]!=0 -> error.
  - An error goes IDLE->DONE with err=1, rdata=0 and no memory strobe.
- SETUP (1 cycle): mem_addr and mem_mode driven. On a store, mem_wdata plus mem_wdata_oe=1. Strobes low.
- STROBE (1 cycle): mem_wr=1 on a store, mem_rd=1 on a load. Address, mode and data held stable.
- Store: STROBE->HOLD. HOLD keeps addr/data/oe one more cycle with mem_wr=0, then goes to DONE.
- Load: STROBE->CAPTURE with mem_rd held high.
  - In CAPTURE, when mem_rd_st=1 the block registers mem_rdata, applies extension, drops mem_rd and goes to DONE.
  - Extension: byte uses [7:0], halfword uses [15:0]; sext=1 copies bit 7/15 upward, otherwise zero-fill.
  - If mem_rd_st stays 0 for TIMEOUT cycles: err=1, rdata=0, go to DONE.
- DONE (1 cycle): pX_ack=1 for the granted port only, rdata/err valid, mem_wdata_oe=0, then IDLE.
- pX_rdata/pX_err hold until the next ack to that port.
- Latency, req seen in IDLE at cycle 0:
  - store ack at cycle 4;
  - load ack at cycle 4 if mem_rd_st is already high in CAPTURE;
  - error ack at cycle 1.
- A req must not be sampled the cycle its ack is high. A master deasserting req after ack re-enters arbitration next IDLE.
- mem_wr and mem_rd are never both high. mem_wdata_oe is never high while mem_rd=1.
- Address arithmetic is not performed here; the memory handles byte lanes big-endian from mem_addr.

Test Plan:
- Reset values: assert rst_n=0 mid-load (in STROBE) -> mem_rd=0 within 0 cycles, no ack. After release, busy=0 and all acks 0.
- p0 word store 0xDEADBEEF @0x8, then p0 word load @0x8 -> store ack cycle 4, load ack cycle 4 with rdata=0xDEADBEEF, err=0. mem_wr high exactly 1 cycle.
- Byte 0x80 stored @0x3:
  - load with sext=1 -> rdata=0xFFFFFF80;
  - load with sext=0 -> rdata=0x00000080.
  - Same pattern for halfword 0x8001 @0x2 -> 0xFFFF8001 / 0x00008001.
- Misalignment: word @0x2, halfword @0x5, mode=3 -> each acks at cycle 1 with err=1, rdata=0, and no mem_rd/mem_wr edge.
- Contention: p0 and p1 request continuously for 4 transactions -> grants alternate p0,p1,p0,p1. No overlap of acks.
- Timeout: bench forces mem_rd_st=0 during load -> ack after TIMEOUT=4 CAPTURE cycles with err=1, mem_rd dropped in DONE.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: one master's single-cycle request / one-cycle ack port
// into dmem_access_ctrl.
interface dmem_access_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [1:0]       mode;
    logic             sext;
    logic             ack;
    logic [WIDTH-1:0] rdata;
    logic             err;
    modport master (output req, we, addr, wdata, mode, sext, input ack, rdata, err);
    modport slave (input req, we, addr, wdata, mode, sext, output ack, rdata, err);
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: arbitrates two masters onto an edge-strobed data memory with
// setup/strobe/hold sequencing, alignment checks, sub-word load extension and read timeout.
module dmem_access_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_access_ctrl_if.slave p0,
    dmem_access_ctrl_if.slave p1,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [1:0]        mem_mode,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic              mem_rd_st,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CAPTURE, DONE} state_t;
    state_t           state;
    logic             rr, gnt, we_q, sext_q;
    logic [1:0]       mode_q;
    logic [7:0]       cnt;
    logic             pick1, any_req, sel_we, sel_sext, bad;
    logic [1:0]       sel_mode;
    logic [WIDTH-1:0] sel_addr, sel_wdata, ext;
    logic             fin, fin_gnt, fin_err;
    logic [WIDTH-1:0] fin_data;
    // rr=1 favours p1 when both masters request in the same IDLE cycle
    assign any_req   = p0.req | p1.req;
    assign pick1     = p1.req & (~p0.req | rr);
    assign sel_we    = pick1 ? p1.we : p0.we;
    assign sel_sext  = pick1 ? p1.sext : p0.sext;
    assign sel_mode  = pick1 ? p1.mode : p0.mode;
    assign sel_addr  = pick1 ? p1.addr : p0.addr;
    assign sel_wdata = pick1 ? p1.wdata : p0.wdata;
    assign bad       = sel_mode == 2'd3 || (sel_mode == 2'd0 && sel_addr[1:0] != 2'd0) ||
                       (sel_mode == 2'd1 && sel_addr[0]);
    assign ext = mode_q == 2'd2 ? {{(WIDTH-8){sext_q & mem_rdata[7]}}, mem_rdata[7:0]} :
                 mode_q == 2'd1 ? {{(WIDTH-16){sext_q & mem_rdata[15]}}, mem_rdata[15:0]} :
                 mem_rdata;
    // completion condition for the transition into DONE, whichever state it comes from
    assign fin      = state == IDLE ? any_req & bad :
                      (state == HOLD || (state == CAPTURE && (mem_rd_st || cnt == 8'(TIMEOUT - 1))));
    assign fin_gnt  = state == IDLE ? pick1 : gnt;
    assign fin_err  = state == IDLE || (state == CAPTURE && !mem_rd_st);
    assign fin_data = (state == CAPTURE && mem_rd_st) ? ext : '0;
    assign busy     = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr           <= 1'b0;
            gnt          <= 1'b0;
            we_q         <= 1'b0;
            sext_q       <= 1'b0;
            mode_q       <= 2'd0;
            cnt          <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wdata_oe <= 1'b0;
            mem_mode     <= 2'd0;
            mem_wr       <= 1'b0;
            mem_rd       <= 1'b0;
            p0.ack       <= 1'b0;
            p0.rdata     <= '0;
            p0.err       <= 1'b0;
            p1.ack       <= 1'b0;
            p1.rdata     <= '0;
            p1.err       <= 1'b0;
        end else begin
            p0.ack <= fin & ~fin_gnt;
            p1.ack <= fin & fin_gnt;
            if (fin && !fin_gnt) begin
                p0.rdata <= fin_data;
                p0.err   <= fin_err;
            end
            if (fin && fin_gnt) begin
                p1.rdata <= fin_data;
                p1.err   <= fin_err;
            end
            case (state)
                IDLE: if (any_req) begin
                    gnt          <= pick1;
                    we_q         <= sel_we;
                    sext_q       <= sel_sext;
                    mode_q       <= sel_mode;
                    mem_addr     <= sel_addr;
                    mem_mode     <= sel_mode;
                    mem_wdata    <= sel_we ? sel_wdata : '0;
                    mem_wdata_oe <= sel_we & ~bad;
                    rr           <= (p0.req & p1.req) ? ~pick1 : rr;
                    state        <= bad ? DONE : SETUP;
                end
                SETUP: begin
                    mem_wr <= we_q;
                    mem_rd <= ~we_q;
                    state  <= STROBE;
                end
                STROBE: begin
                    mem_wr <= 1'b0;
                    cnt    <= '0;
                    state  <= we_q ? HOLD : CAPTURE;
                end
                HOLD: begin
                    mem_wdata_oe <= 1'b0;
                    state        <= DONE;
                end
                CAPTURE: if (mem_rd_st || cnt == 8'(TIMEOUT - 1)) begin
                    mem_rd <= 1'b0;
                    state  <= DONE;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and random transactions against a byte-array
// reference model, with a behavioural big-endian memory on the strobe side.
module tb_dmem_access_ctrl;
    localparam int W  = 32;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic mem_wdata_oe, mem_wr, mem_rd, mem_rd_st, busy;
    logic [1:0] mem_mode;
    logic st_en = 1'b1;
    int cmp = 0, errs = 0;
    int wr_edges = 0, rd_edges = 0, wr_hi = 0, viol = 0, acks_seen = 0;
    int fav = 0;
    logic [7:0] dev [0:255];
    logic [7:0] ref_mem [0:255];
    always #5 clk = ~clk;
    dmem_access_ctrl_if #(.WIDTH(W)) p0 ();
    dmem_access_ctrl_if #(.WIDTH(W)) p1 ();
    dmem_access_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .p0(p0), .p1(p1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
        .mem_rdata(mem_rdata), .mem_mode(mem_mode), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_rd_st(mem_rd_st), .busy(busy)
    );
    // memory device: writes on the rising edge of mem_wr, drives right-justified data while mem_rd
    always @(posedge mem_wr) begin
        case (mem_mode)
            2'd0: begin
                dev[mem_addr[7:0]]        = mem_wdata[31:24];
                dev[mem_addr[7:0] + 8'd1] = mem_wdata[23:16];
                dev[mem_addr[7:0] + 8'd2] = mem_wdata[15:8];
                dev[mem_addr[7:0] + 8'd3] = mem_wdata[7:0];
            end
            2'd1: begin
                dev[mem_addr[7:0]]        = mem_wdata[15:8];
                dev[mem_addr[7:0] + 8'd1] = mem_wdata[7:0];
            end
            default: dev[mem_addr[7:0]] = mem_wdata[7:0];
        endcase
    end
    always_comb begin
        mem_rdata = '0;
        if (mem_rd)
            mem_rdata = mem_mode == 2'd0 ? {dev[mem_addr[7:0]], dev[mem_addr[7:0] + 8'd1],
                                            dev[mem_addr[7:0] + 8'd2], dev[mem_addr[7:0] + 8'd3]} :
                        mem_mode == 2'd1 ? {16'd0, dev[mem_addr[7:0]], dev[mem_addr[7:0] + 8'd1]} :
                        {24'd0, dev[mem_addr[7:0]]};
    end
    assign mem_rd_st = mem_rd & st_en;
    always @(posedge mem_wr) wr_edges++;
    always @(posedge mem_rd) rd_edges++;
    always @(negedge clk) begin
        if (mem_wr) wr_hi++;
        if ((mem_wr && mem_rd) || (mem_wdata_oe && mem_rd) || (p0.ack && p1.ack)) viol++;
        if (p0.ack || p1.ack) acks_seen++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    function automatic int nbytes(input logic [1:0] m);
        return m == 2'd0 ? 4 : m == 2'd1 ? 2 : 1;
    endfunction
    function automatic logic [31:0] ref_load(input int a, input logic [1:0] m, input logic s);
        longint v = 0;
        int n = nbytes(m);
        for (int k = 0; k < n; k++) v = v * 256 + ref_mem[a + k];
        if (s && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction
    task automatic ref_store(input int a, input logic [1:0] m, input logic [31:0] d);
        int n = nbytes(m);
        for (int k = 0; k < n; k++) ref_mem[a + k] = 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
    endtask
    task automatic set_req(input int port, input logic r, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] m, input logic s);
        if (port == 0) begin
            p0.req = r; p0.we = we; p0.addr = a; p0.wdata = d; p0.mode = m; p0.sext = s;
        end else begin
            p1.req = r; p1.we = we; p1.addr = a; p1.wdata = d; p1.mode = m; p1.sext = s;
        end
    endtask
    // called one delta after a rising edge with the DUT idle; that edge-to-edge cycle is cycle 0
    task automatic do_op(input string tag, input int port, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [1:0] m, input logic s);
        int lat, wr0, rd0, wh0;
        logic bad, e, other, rd_at_ack, timeout;
        logic [31:0] rd;
        bad = m == 2'd3 || (m == 2'd0 && a % 4 != 0) || (m == 2'd1 && a % 2 != 0);
        timeout = !bad && !we && !st_en;
        wr0 = wr_edges; rd0 = rd_edges; wh0 = wr_hi;
        set_req(port, 1'b1, we, a, d, m, s);
        lat = 41; rd = 'x; e = 1'bx; other = 1'bx; rd_at_ack = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (port == 0 ? p0.ack : p1.ack) begin
                lat = c;
                rd = port == 0 ? p0.rdata : p1.rdata;
                e = port == 0 ? p0.err : p1.err;
                other = port == 0 ? p1.ack : p0.ack;
                rd_at_ack = mem_rd;
                break;
            end
        end
        set_req(port, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        check({tag, "_lat"}, lat, bad ? 1 : timeout ? 3 + TO : 4);
        check({tag, "_err"}, {31'd0, e}, {31'd0, bad | timeout});
        check({tag, "_other_ack"}, {31'd0, other}, 32'd0);
        check({tag, "_rd_in_done"}, {31'd0, rd_at_ack}, 32'd0);
        if (bad || !we) check({tag, "_rdata"}, rd, (bad || timeout) ? 32'd0 : ref_load(a, m, s));
        check({tag, "_wr_edges"}, wr_edges - wr0, (!bad && we) ? 1 : 0);
        check({tag, "_rd_edges"}, rd_edges - rd0, (!bad && !we) ? 1 : 0);
        if (!bad && we) begin
            check({tag, "_wr_hi_cycles"}, wr_hi - wh0, 1);
            ref_store(a, m, d);
        end
        @(posedge clk); #1;
    endtask
    initial begin
        int got, both, a0;
        logic [31:0] ra, rd;
        logic [1:0] rm;
        for (int i = 0; i < 256; i++) begin dev[i] = 8'd0; ref_mem[i] = 8'd0; end
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        #1;
        check("reset_mem_outs", {mem_addr, mem_wdata}, 32'd0);
        check("reset_ctrl", {26'd0, mem_wdata_oe, mem_mode, mem_wr, mem_rd, busy}, 32'd0);
        check("reset_p0", p0.rdata | {31'd0, p0.ack | p0.err}, 32'd0);
        check("reset_p1", p1.rdata | {31'd0, p1.ack | p1.err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        // reset while the load strobe is up
        set_req(0, 1'b1, 1'b0, 32'h8, 32'd0, 2'd0, 1'b0);
        got = acks_seen;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midload_rd_before", {31'd0, mem_rd}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midload_rd_dropped", {31'd0, mem_rd}, 32'd0);
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("midload_busy", {31'd0, busy}, 32'd0);
        check("midload_acks", {30'd0, p0.ack, p1.ack}, 32'd0);
        check("midload_no_ack", acks_seen - got, 0);
        do_op("st_word", 0, 1'b1, 32'h8, 32'hDEADBEEF, 2'd0, 1'b0);
        do_op("ld_word", 0, 1'b0, 32'h8, 32'd0, 2'd0, 1'b0);
        check("ld_word_value", ref_load(8, 2'd0, 1'b0), 32'hDEADBEEF);
        do_op("st_byte", 0, 1'b1, 32'h3, 32'h80, 2'd2, 1'b0);
        do_op("ld_byte_s", 0, 1'b0, 32'h3, 32'd0, 2'd2, 1'b1);
        do_op("ld_byte_z", 1, 1'b0, 32'h3, 32'd0, 2'd2, 1'b0);
        do_op("st_half", 1, 1'b1, 32'h2, 32'h8001, 2'd1, 1'b0);
        do_op("ld_half_s", 0, 1'b0, 32'h2, 32'd0, 2'd1, 1'b1);
        do_op("ld_half_z", 1, 1'b0, 32'h2, 32'd0, 2'd1, 1'b0);
        do_op("mis_word", 0, 1'b0, 32'h2, 32'd0, 2'd0, 1'b0);
        do_op("mis_half", 1, 1'b1, 32'h5, 32'h1234, 2'd1, 1'b0);
        do_op("mode3", 0, 1'b0, 32'h0, 32'd0, 2'd3, 1'b0);
        // both masters request continuously; grants must alternate starting at p0
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_0F0F, 2'd0, 1'b0);
        set_req(1, 1'b1, 1'b1, 32'h14, 32'h1357_9BDF, 2'd0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            got = -1; both = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                if (p0.ack || p1.ack) begin
                    both = (p0.ack && p1.ack) ? 1 : 0;
                    got = p1.ack ? 1 : 0;
                    break;
                end
            end
            check("cont_grant", got, fav);
            check("cont_overlap", both, 0);
            fav = 1 - fav;
        end
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
        ref_store(32'h10, 2'd0, 32'hA5A5_0F0F);
        ref_store(32'h14, 2'd0, 32'h1357_9BDF);
        @(posedge clk); #1;
        do_op("cont_ld0", 1, 1'b0, 32'h10, 32'd0, 2'd0, 1'b0);
        do_op("cont_ld1", 0, 1'b0, 32'h14, 32'd0, 2'd0, 1'b0);
        st_en = 1'b0;
        do_op("timeout", 1, 1'b0, 32'h8, 32'd0, 2'd0, 1'b0);
        st_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            rm = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'(($urandom_range(0, 2)));
            a0 = $urandom_range(0, 15) * 4 + (rm == 2'd2 ? $urandom_range(0, 3) : rm == 2'd1 ? 2 * $urandom_range(0, 1) : 0);
            if ($urandom_range(0, 7) == 0) a0 = a0 + 1;
            ra = 32'(a0);
            rd = $urandom;
            rd = rm == 2'd1 ? rd & 32'hFFFF : rm == 2'd2 ? rd & 32'hFF : rd;
            do_op("rand", $urandom_range(0, 1), 1'($urandom_range(0, 1)), ra, rd, rm, 1'($urandom_range(0, 1)));
        end
        check("protocol_violations", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
